// File: rtl/prog_loader_pkg.sv
// Shared loader constants, FSM state encoding and header validation.
package prog_loader_pkg;

    localparam int DEPTH = 16;
    localparam int AW = 4;
    localparam logic [7:0] MAGIC = 8'hA5;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_HI   = 3'd1;
    localparam state_t ST_LO   = 3'd2;
    localparam state_t ST_WR   = 3'd3;
    localparam state_t ST_CHK  = 3'd4;
    localparam state_t ST_DONE = 3'd5;
    localparam state_t ST_ERR  = 3'd6;

    // Header: magic in [15:8], zero pad in [7:5], instruction count 1..DEPTH in [4:0].
    function automatic logic hdr_ok(input logic [15:0] h);
        return (h[15:8] == MAGIC) && (h[7:5] == 3'b000) &&
               (h[4:0] != 5'd0) && (int'(h[4:0]) <= DEPTH);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Host word stream plus instruction memory write port.
interface prog_loader_if #(parameter int AW = 4);
    logic [15:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Fills instruction memory from the host stream and holds the core in reset
// until a checksum-verified program has been written.
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic          clk,
    input  logic          sys_rst,
    prog_loader_if.slave  bus,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t        state;
    logic [AW-1:0] idx;
    logic [4:0]    n_q;
    logic [15:0]   hi_q;
    logic [15:0]   csum;
    logic          accept;

    assign bus.in_ready = !sys_rst && (state != ST_WR);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state          <= ST_IDLE;
            idx            <= '0;
            n_q            <= '0;
            hi_q           <= '0;
            csum           <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            core_rst       <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            bus.imem_we <= 1'b0;
            case (state)
                // Any word seen outside a load is a header, even after DONE/ERR.
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (accept) begin
                        idx      <= '0;
                        csum     <= '0;
                        n_q      <= bus.in_data[4:0];
                        done     <= 1'b0;
                        core_rst <= 1'b1;
                        if (hdr_ok(bus.in_data)) begin
                            state <= ST_HI;
                            busy  <= 1'b1;
                            err   <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                ST_HI: begin
                    if (accept) begin
                        hi_q  <= bus.in_data;
                        csum  <= csum ^ bus.in_data;
                        state <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (accept) begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_addr  <= idx;
                        bus.imem_wdata <= {hi_q, bus.in_data};
                        csum           <= csum ^ bus.in_data;
                        state          <= ST_WR;
                    end
                end
                ST_WR: begin
                    idx   <= idx + AW'(1);
                    state <= ({1'b0, idx} == n_q - 5'd1) ? ST_CHK : ST_HI;
                end
                ST_CHK: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (bus.in_data == csum) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized loads checked against a stream-level reference model.
module tb_prog_loader;

    logic clk = 1'b0;
    logic sys_rst;
    logic core_rst, busy, done, err;

    prog_loader_if #(.AW(4)) ifc();

    prog_loader dut (
        .clk      (clk),
        .sys_rst  (sys_rst),
        .bus      (ifc),
        .core_rst (core_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] stream[$];
    logic [35:0] exp_w[$];
    logic [35:0] wq[$];
    bit          exp_ok;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Log every write pulse; outside reset, in_ready must be low exactly while a write is out.
    always @(negedge clk) begin
        if (ifc.imem_we) wq.push_back({ifc.imem_addr, ifc.imem_wdata});
        if (!sys_rst) chk("rdy_vs_we", ifc.in_ready, !ifc.imem_we);
    end

    // Reference: decode the whole stream straight from the format rules.
    task automatic model_stream();
        logic [15:0] h, x, hi, lo;
        int n;
        exp_w.delete();
        exp_ok = 1'b0;
        h = stream[0];
        n = int'(h[4:0]);
        if (h[15:8] != 8'hA5 || h[7:5] != 3'b000 || n == 0 || n > 16) return;
        x = 16'h0;
        for (int i = 0; i < n; i++) begin
            hi = stream[1 + 2*i];
            lo = stream[2 + 2*i];
            x ^= hi ^ lo;
            exp_w.push_back({4'(i), hi, lo});
        end
        exp_ok = (stream[1 + 2*n] == x);
    endtask

    task automatic send_word(input logic [15:0] w, input bit gaps);
        int cnt;
        if (gaps && $urandom_range(0, 1) == 1) begin
            ifc.in_valid = 1'b0;
            ifc.in_data  = 16'($urandom);
            @(posedge clk); #1;
        end
        ifc.in_data  = w;
        ifc.in_valid = 1'b1;
        cnt = 0;
        while (!ifc.in_ready && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (cnt >= 50) chk("stall_timeout", 1, 0);
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_done"}, done, exp_ok);
        chk({tag, "_err"}, err, !exp_ok);
        chk({tag, "_core_rst"}, core_rst, !exp_ok);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic run_load(input string tag, input bit gaps);
        model_stream();
        wq.delete();
        foreach (stream[i]) send_word(stream[i], gaps);
        chk_status(tag);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_nwr"}, wq.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wq.size(); i++)
            chk({tag, "_wr"}, wq[i], exp_w[i]);
        chk_status({tag, "_hold"});
    endtask

    task automatic build(input int n, input int mode);
        logic [15:0] x, w;
        stream.delete();
        stream.push_back({8'hA5, 3'b000, 5'(n)});
        if (mode == 3) begin
            case ($urandom_range(0, 3))
                0: begin
                    w = 16'($urandom);
                    while (w[15:8] == 8'hA5) w = 16'($urandom);
                    stream[0][15:8] = w[15:8];
                end
                1: stream[0][7:5] = 3'($urandom_range(1, 7));
                2: stream[0][4:0] = 5'd0;
                default: stream[0][4:0] = 5'($urandom_range(17, 31));
            endcase
            return;
        end
        x = 16'h0;
        for (int i = 0; i < 2*n; i++) begin
            w = 16'($urandom);
            x ^= w;
            stream.push_back(w);
        end
        stream.push_back(mode == 2 ? x ^ (16'h1 << $urandom_range(0, 15)) : x);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"}, ifc.in_ready, 1'b0);
        chk({tag, "_we"}, ifc.imem_we, 1'b0);
        chk({tag, "_addr"}, ifc.imem_addr, 4'h0);
        chk({tag, "_wdata"}, ifc.imem_wdata, 32'h0);
        chk({tag, "_core_rst"}, core_rst, 1'b1);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
    endtask

    initial begin
        sys_rst      = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.in_data  = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        sys_rst = 1'b0;
        @(posedge clk); #1;

        stream = '{16'hA502, 16'h0841, 16'h0005, 16'h1000, 16'h0003, 16'h1847};
        run_load("good", 1'b0);
        chk("good_exp_ok", exp_ok, 1'b1);

        stream = '{16'hA502, 16'h0841, 16'h0005, 16'h1000, 16'h0003, 16'h1846};
        run_load("badsum", 1'b0);

        stream = '{16'hA500};
        run_load("badhdr0", 1'b0);
        stream = '{16'hA511};
        run_load("badhdr1", 1'b0);
        stream = '{16'h5A02};
        run_load("badhdr2", 1'b0);

        stream = '{16'hA502, 16'h0841, 16'h0005, 16'h1000, 16'h0003, 16'h1847};
        run_load("bp", 1'b1);

        build(16, 0);
        run_load("full", 1'b0);

        // Abort after the third data word: only instruction 0 may be written.
        wq.delete();
        send_word(16'hA502, 1'b0);
        send_word(16'h0841, 1'b0);
        send_word(16'h0005, 1'b0);
        send_word(16'h1000, 1'b0);
        sys_rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("midrst");
        sys_rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_nwr", wq.size(), 1);
        if (wq.size() > 0) chk("midrst_wr0", wq[0], {4'h0, 32'h08410005});
        stream = '{16'hA502, 16'h0841, 16'h0005, 16'h1000, 16'h0003, 16'h1847};
        run_load("after_rst", 1'b0);

        for (int t = 0; t < 25; t++) begin
            build($urandom_range(1, 16), $urandom_range(0, 3));
            run_load("rand", 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader that fills the processor's 16-entry, 32-bit instruction memory from a 16-bit host word stream, replacing the file-based preload. It sits between the host-side input port and the instruction memory write port. It holds the core in reset until a complete, checksum-verified program has been written, then releases it.

## Interface
- DEPTH, 16, number of instruction memory entries (max program length)
- AW, 4, instruction memory address width (log2 DEPTH)
- MAGIC, 8'hA5, required value of header bits [15:8]
- clk  in  1  system clock
- sys_rst  in  1  reset, synchronous, active-high
- in_data  in  16  host word
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts in_data this cycle; a transfer occurs when in_valid & in_ready
- imem_we  out  1  one-cycle instruction memory write strobe
- imem_addr  out  AW  write address
- imem_wdata  out  32  instruction word
- core_rst  out  1  reset to the processor core; high until a load succeeds
- busy  out  1  a load is in progress
- done  out  1  last load succeeded
- err  out  1  last load failed (bad header or checksum)

## Operation
- Stream format: header, then 2N data words (high half IR[31:16] first, then low half IR[15:0]) for N instructions, then one checksum word.
- Header is valid when [15:8]==MAGIC, [7:5]==0, and N=[4:0] is in 1..DEPTH.
- Checksum is the 16-bit XOR of all 2N data words. The header is excluded.
- FSM states and transitions:
  - IDLE: on header accept, go to HI if the header is valid, else ERR.
  - HI: on accept, latch the high half and go to LO.
  - LO: on accept, latch the low half and go to WR.
  - WR: imem_we=1 at imem_addr=idx, in_ready=0. Increment idx. Go to HI if idx≠N-1, else CHK.
  - CHK: on accept, go to DONE if the word equals the running XOR, else ERR.
  - DONE / ERR: any accepted word is treated as a new header. It is evaluated exactly as in IDLE, and core_rst is re-asserted.
- Writes land in memory as received. After ERR, memory contents are undefined and a full reload is required. The core stays in reset.
- Entries with addresses ≥N are not written and keep their old values.
- idx and the running XOR clear on every header accept.

## Timing
- Reset values (sys_rst high at a clk edge): state=IDLE, in_ready=0 while sys_rst is high, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, busy=0, done=0, err=0.
- in_ready is decoded from state: 1 in IDLE/HI/LO/CHK/DONE/ERR, 0 in WR.
- All other outputs are registered.
- Low-half accept at edge t puts imem_we high for exactly the cycle after t, with imem_wdata={hi,lo}.
- The sustained rate is 3 cycles per instruction when in_valid is held high.
- A checksum accept at edge t gives done=1 and core_rst=0 from t+1. An ERR entry gives err=1 from t+1.
- busy is 1 in HI/LO/WR/CHK and 0 otherwise.
- A header accept in DONE/ERR clears done/err and sets core_rst=1 on the next cycle.
- in_valid gaps stall the FSM in its current state with no side effects.
- in_data is ignored when in_valid=0.
- sys_rst mid-load aborts immediately: no further imem_we pulses occur and state returns to IDLE.

## Structure
- Shared processor package holds: MAGIC, DEPTH, AW, and the FSM state enum (IDLE, HI, LO, WR, CHK, DONE, ERR).
- Single module with no submodules.
- The checksum accumulator is an inline 16-bit register.

## Test plan
- Good load: A502, 0841, 0005, 1000, 0003, checksum 1847 → two imem_we pulses, (addr 0, 08410005) then (addr 1, 10000003); done=1, core_rst=0.
- Bad checksum: same stream ending 1846 → both writes occur; err=1, done=0, core_rst stays 1.
- Bad header: A500, then A511, then 5A02 → each one enters ERR with no imem_we pulse; err=1.
- Backpressure: the good load with in_valid toggling every other cycle → in_ready=0 exactly in WR cycles; same writes and checksum result; no word lost or duplicated.
- Full depth: header A510 followed by 32 words and the correct XOR → 16 writes at addresses 0..15 in order; done=1.
- Reset mid-load: sys_rst pulsed after the third data word → no write for instruction 1; outputs return to reset values; a following good load succeeds.
